// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with valid/ready on both sides.
//
// S1 registers the incoming op/operands; S2 computes the result from the S1
// registers and registers result + flags. Backpressure propagates from
// out_ready back to in_ready combinationally. Empty stages accept new data
// even while the consumer stalls, so two transactions can be held.
//
// Ports:
//   clock, reset      clock (posedge) and async active-high reset
//   in_valid/in_ready input handshake; op[3:0], a, b operands
//   out_valid/out_ready output handshake
//   out               result
//   out_zero          result == 0
//   out_carry         carry-out for ADD/SUB, else 0
//   out_overflow      signed overflow for ADD/SUB, else 0
//                     (exists only when ALU_PIPE_OVERFLOW_EN is defined)
//
// Build option: define ALU_PIPE_OVERFLOW_EN to add the out_overflow port.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_carry
`ifdef ALU_PIPE_OVERFLOW_EN
  ,
  output logic             out_overflow
`endif
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_NAND = 4'h1, OP_OR   = 4'h2, OP_NOR  = 4'h3,
    OP_XOR  = 4'h4, OP_XNOR = 4'h5, OP_NOTA = 4'h6, OP_NOTB = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_SLL  = 4'hA, OP_SRL  = 4'hB,
    OP_SRA  = 4'hC, OP_SLT  = 4'hD, OP_SLTU = 4'hE, OP_PASS = 4'hF
  } op_e;

  // Stage 1 registers
  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2 registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_carry;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  // An empty or draining S2 lets S1 move; an empty or moving S1 can take input.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  assign w_sh   = r_s1_b[SHW-1:0];
  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  // a + ~b + 1: the carry-out is set exactly when a >= b unsigned.
  assign w_diff = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (r_s1_op)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_NAND: w_res = ~(r_s1_a & r_s1_b);
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
      OP_NOTA: w_res = ~r_s1_a;
      OP_NOTB: w_res = ~r_s1_b;
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
      end
      OP_SLL:  w_res = r_s1_a << w_sh;
      OP_SRL:  w_res = r_s1_a >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(r_s1_a) >>> w_sh);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (r_s1_a < r_s1_b)};
      OP_PASS: w_res = r_s1_a;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_AND;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      r_s1_op    <= op_e'(op);
      r_s1_a     <= a;
      r_s1_b     <= b;
    end
  end

  // Result/flags load alongside out_valid even on bubbles; consumers only
  // look at them when out_valid is set. They hold while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      r_out       <= w_res;
      r_zero      <= (w_res == '0);
      r_carry     <= w_carry;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_zero  = r_zero;
  assign out_carry = r_carry;

`ifdef ALU_PIPE_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf;

  // ADD overflows when like-signed operands give a differently-signed sum;
  // SUB when operand signs differ and the result sign departs from a.
  always_comb begin
    w_ovf = 1'b0;
    case (r_s1_op)
      OP_ADD: w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                      (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
      OP_SUB: w_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                      (w_res[WIDTH-1] != r_s1_a[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_ovf <= 1'b0;
    else if (w_s2_en) r_ovf <= w_ovf;
  end

  assign out_overflow = r_ovf;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed vectors with literal
// expectations, a backpressure scenario, a random stream and a mid-flight
// reset. A queue-based reference model is compared on every output cycle.
module tb_alu_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        out_zero;
  logic        out_carry;
`ifdef ALU_PIPE_OVERFLOW_EN
  logic        out_overflow;
`endif

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_zero(out_zero), .out_carry(out_carry)
`ifdef ALU_PIPE_OVERFLOW_EN
    , .out_overflow(out_overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint unsigned s;
    int sx = $signed(x);
    int sy = $signed(y);
    int sh = int'(y[4:0]);
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      4'h0: e.r = x & y;
      4'h1: e.r = ~(x & y);
      4'h2: e.r = x | y;
      4'h3: e.r = ~(x | y);
      4'h4: e.r = x ^ y;
      4'h5: e.r = ~(x ^ y);
      4'h6: e.r = ~x;
      4'h7: e.r = ~y;
      4'h8: begin
        s   = ux + uy;
        e.r = s[31:0];
        e.c = s[32];
        e.v = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      4'h9: begin
        e.r = x - y;
        e.c = (ux >= uy);
        e.v = (x[31] != y[31]) && (e.r[31] != x[31]);
      end
      4'hA: e.r = x << sh;
      4'hB: e.r = x >> sh;
      4'hC: e.r = 32'(sx >>> sh);
      4'hD: e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'hE: e.r = (ux < uy) ? 32'd1 : 32'd0;
      default: e.r = x;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Compare process: inputs change #1 after posedge, so negedge sees the
  // handshake values that the next posedge will act on.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h with no pending transaction", out);
        end else begin
          e = q[0];
          chk("model_out", out, e.r);
          chk("model_zero", {31'b0, out_zero}, {31'b0, e.z});
          chk("model_carry", {31'b0, out_carry}, {31'b0, e.c});
`ifdef ALU_PIPE_OVERFLOW_EN
          chk("model_ovf", {31'b0, out_overflow}, {31'b0, e.v});
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b));
    end
  end

  // Called #1 after a posedge; returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
    end
    @(posedge clock); #1;
  endtask

  task automatic directed(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic ec, input logic ev);
    out_ready = 1'b1;
    send(o, x, y);
    in_valid = 1'b0;
    chk({name, "_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clock); #1;
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_out"}, out, er);
    chk({name, "_zero"}, {31'b0, out_zero}, {31'b0, ez});
    chk({name, "_carry"}, {31'b0, out_carry}, {31'b0, ec});
`ifdef ALU_PIPE_OVERFLOW_EN
    chk({name, "_ovf"}, {31'b0, out_overflow}, {31'b0, ev});
`else
    if (ev === 1'bx) $display("note: overflow expectation unknown");
`endif
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(posedge clock); #1;
    end
    chk("drain_pending", q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] pool [8];
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h0000_0001; pool[5] = 32'h0000_001F;
    pool[6] = 32'h8000_00F0; pool[7] = 32'h0000_0104;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_zero", {31'b0, out_zero}, 32'd0);
    chk("rst_carry", {31'b0, out_carry}, 32'd0);
`ifdef ALU_PIPE_OVERFLOW_EN
    chk("rst_ovf", {31'b0, out_overflow}, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;

    directed("add_wrap", 4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    directed("sub_ovf",  4'h9, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    directed("sra",      4'hC, 32'h8000_00F0, 32'h0000_0104, 32'hF800_000F, 1'b0, 1'b0, 1'b0);
    directed("srl",      4'hB, 32'h8000_00F0, 32'h0000_0104, 32'h0800_000F, 1'b0, 1'b0, 1'b0);
    directed("slt",      4'hD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    directed("sltu",     4'hE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    directed("sub_lt",   4'h9, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    directed("nor",      4'h3, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

    // Backpressure: two accepts fill the pipe, third is refused while stalled.
    out_ready = 1'b0;
    send(4'h4, 32'h1111_0000, 32'h0000_1111);
    send(4'h4, 32'h2222_0000, 32'h0000_2222);
    op = 4'h4; a = 32'h3333_0000; b = 32'h0000_3333; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_out_hold", out, 32'h1111_1111);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(4'h4, 32'h3333_0000, 32'h0000_3333);
    send(4'h4, 32'h4444_0000, 32'h0000_4444);
    drain();

    // Random stream, including stalls, bubbles and boundary operands.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 4'(i % 16 == 0 ? $urandom_range(0, 15) : (i / 7) % 16);
      a         = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      b         = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 15) == 0) b = a;
      @(posedge clock); #1;
    end
    drain();

    // Reset with a full, stalled pipe.
    out_ready = 1'b0;
    send(4'h8, 32'h0000_0010, 32'h0000_0020);
    send(4'h8, 32'h0000_0030, 32'h0000_0040);
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    directed("post_rst_add", 4'h8, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshaking on both sides. It is the next-generation replacement for the fixed 32-bit logic-only ALU. It adds arithmetic, shift and compare ops, zero and carry flags, and full downstream backpressure. It sits between an operand-issue stage and a result-writeback consumer, and is simulated under Verilator.

## Interface
Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, ≥ 8.

Ports:
- clock  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  op/a/b valid this cycle
- in_ready  out  1  block accepts input this cycle; transfer when in_valid && in_ready
- op  in  4  operation code (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- out  out  WIDTH  result
- out_zero  out  1  out == 0
- out_carry  out  1  carry flag (see Operation)
- out_overflow  out  1  signed overflow; present only with ALU_PIPE_OVERFLOW_EN

## Operation
- Op codes:
  - 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR; 6 NOT_A (~a); 7 NOT_B (~b).
  - 8 ADD (a+b); 9 SUB (a−b); A SLL (a<<sh); B SRL (a>>sh, logical); C SRA (a>>>sh, arithmetic).
  - D SLT (signed a<b → 1 else 0); E SLTU (unsigned a<b → 1 else 0); F PASS_A (a).
- Shift amount sh = b[$clog2(WIDTH)-1:0]. Upper bits of b are ignored.
- Arithmetic is modulo 2^WIDTH.
- out_carry:
  - ADD: carry-out of a+b.
  - SUB: carry-out of a+~b+1, i.e. 1 when a ≥ b unsigned.
  - All other ops: 0.
- out_zero is computed from the registered result, for every op.
- Stage 1 (S1) registers op, a, b and valid on input transfer.
- Stage 2 (S2) computes the result from the S1 registers and registers out, flags and out_valid.
- Enables:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en. This is combinational from out_ready and state.
- S1 loads on s1_en: s1_valid <= in_valid, with operands captured.
- S2 loads on s2_en: out_valid <= s1_valid, with results captured.
- While out_valid && !out_ready, out, out_zero, out_carry and out_overflow hold stable.
- Bubbles collapse: an empty S2 accepts from S1 even when out_ready=0.
- Result and flag registers may update when the loaded valid is 0. Consumers ignore them unless out_valid=1.

## Timing
- Reset values: out_valid=0, out=0, out_zero=0, out_carry=0, out_overflow=0, S1 valid=0, S1 operands=0.
- in_ready=1 while reset is deasserted and the pipe is empty.
- Latency: an input transfer on cycle N produces out_valid=1 on cycle N+2, if out_ready was high or S2 was empty.
- Throughput: 1 op/cycle while out_ready=1 continuously.
- Capacity: 2 transactions (S1 + S2).
- Full pipe with out_ready=0: in_ready=0. No input is lost. Data on a/b/op with in_ready=0 is not consumed.
- Simultaneous output transfer and input transfer on a full pipe: both occur in the same cycle with no bubble.
- Reset asserted mid-operation: in-flight transactions are discarded. Outputs go to reset values asynchronously.
- in_valid is sampled only at posedge. No combinational path from in_valid to in_ready.

## Configuration
- Macro: ALU_PIPE_OVERFLOW_EN.
- Defined:
  - Port out_overflow exists and is registered in S2.
  - ADD: 1 when a and b have equal sign and the result sign differs.
  - SUB: 1 when a and b differ in sign and the result sign differs from a.
  - All other ops: 0.
  - Held during stall like the other flags.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then ADD a=0xFFFF_FFFF b=0x0000_0001, out_ready=1 → two cycles later out=0, out_zero=1, out_carry=1. With ALU_PIPE_OVERFLOW_EN, out_overflow=0.
- SUB a=0x8000_0000 b=0x0000_0001 → out=0x7FFF_FFFF, out_carry=1. With ALU_PIPE_OVERFLOW_EN, out_overflow=1.
- SRA a=0x8000_00F0 b=0x0000_0104 → out=0xF800_000F. Then SRL with the same operands → 0x0800_000F. SLT a=0xFFFF_FFFF b=1 → 1. SLTU with the same operands → 0.
- Backpressure: issue 4 back-to-back XOR ops, hold out_ready=0 → in_ready falls after 2 accepts and out holds its first result. Release out_ready → all 4 results emerge in order, none lost or duplicated.
- Random op/a/b/in_valid/out_ready stream over 10k cycles → output sequence matches a reference model in order. Every op code 0–F is exercised.
- Assert reset while the pipe is full and stalled → out_valid=0 and out=0 immediately. The first post-reset result comes only from new inputs.
